mips_isa_simulator: RTL and testbench

- Behavioural, single-cycle MIPS-32 subset processor model, for use as the golden instruction-level simulator in Project 1.
- Executes one instruction per rising clock edge from an internal instruction memory.
- Architectural state lives in internal arrays that benches load and inspect hierarchically; there are no data ports.

---
 rtl/mips_sim_pkg.sv | 48 ++++
 rtl/mips_sim_alu.sv | 43 ++++
 rtl/mips_isa_simulator.sv | 251 +++++++++++++++++++++++++
 tb/tb_mips_isa_simulator.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_sim_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_sim_pkg
//  Description : Shared definitions for the MIPS-32 subset instruction-level
//                simulator: opcode/funct encodings, the ALU operation enum
//                and the 16-bit immediate sign-extension helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_sim_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] c_F_SLL = 6'h00;
    localparam logic [5:0] c_F_SRL = 6'h02;
    localparam logic [5:0] c_F_JR  = 6'h08;
    localparam logic [5:0] c_F_ADD = 6'h20;
    localparam logic [5:0] c_F_SUB = 6'h22;
    localparam logic [5:0] c_F_AND = 6'h24;
    localparam logic [5:0] c_F_OR  = 6'h25;
    localparam logic [5:0] c_F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6
    } alu_op_e;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_sim_alu.sv
`default_nettype none
// ============================================================================
//  Module      : mips_sim_alu
//  Description : Combinational ALU for the MIPS-32 subset simulator.
//                Add/sub wrap modulo 2^32, SLT compares signed, shifts act
//                on operand b by the instruction shamt (SRL zero-fills).
//  Ports       : i_a       [31:0] operand a (rs)
//                i_b       [31:0] operand b (rt or sign-extended immediate)
//                i_shamt   [4:0]  shift amount
//                i_alu_op  alu_op_e operation select
//                o_result  [31:0] result
//                o_zero           result == 0 (branch compare)
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_sim_alu
    import mips_sim_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [4:0]  i_shamt,
    input  alu_op_e     i_alu_op,
    output logic [31:0] o_result,
    output logic        o_zero
);

    always_comb begin
        o_result = 32'd0;
        case (i_alu_op)
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_SLT: o_result = ($signed(i_a) < $signed(i_b)) ? 32'd1 : 32'd0;
            ALU_SLL: o_result = i_b << i_shamt;
            ALU_SRL: o_result = i_b >> i_shamt;
            default: o_result = 32'd0;
        endcase
    end

    assign o_zero = (o_result == 32'd0);

endmodule
`default_nettype wire

// File: rtl/mips_isa_simulator.sv
`default_nettype none
// ============================================================================
//  Module      : mips_isa_simulator
//  Description : Single-cycle MIPS-32 subset golden model. One instruction is
//                fetched from Instr_Mem[PC[31:2]] and fully executed on every
//                rising clock edge with reset low. Architectural state
//                (Instr_Mem, Reg_File, Data_Mem, PC) is kept in internal
//                arrays that are loaded and inspected hierarchically.
//  Ports       : clk_i  clock, all state updates on the rising edge
//                rst_i  synchronous active-high reset (PC, Reg_File and
//                       Data_Mem cleared; Instr_Mem untouched)
//  Parameters  : IMEM_DEPTH  instruction memory depth (32-bit words)
//                DMEM_DEPTH  data memory depth (32-bit words)
//  Options     : SIM_TRACE_EN  when defined, prints a per-instruction trace
//                (cycle, PC, instruction, register/memory write).
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_isa_simulator
    import mips_sim_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
)(
    input  logic clk_i,
    input  logic rst_i
);

    localparam int c_IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int c_DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    // ------------------------------------------------------------------
    // Architectural state (names are accessed hierarchically by benches)
    // ------------------------------------------------------------------
    logic        [31:0] Instr_Mem [0:IMEM_DEPTH-1];
    logic signed [31:0] Reg_File  [0:31];
    logic        [31:0] Data_Mem  [0:DMEM_DEPTH-1];
    logic        [31:0] PC;

    // ------------------------------------------------------------------
    // Fetch
    // ------------------------------------------------------------------
    logic [29:0] w_pc_widx;
    logic        w_pc_in_range;
    logic [31:0] w_instr;
    logic [31:0] w_pc_plus4;

    assign w_pc_widx     = PC[31:2];
    assign w_pc_in_range = ({2'b00, w_pc_widx} < 32'(IMEM_DEPTH));
    // An all-zero word decodes as "sll $0,$0,0", whose write to $0 is
    // discarded, so an out-of-range fetch behaves as a NOP.
    assign w_instr       = w_pc_in_range ? Instr_Mem[w_pc_widx[c_IAW-1:0]] : 32'h0;
    assign w_pc_plus4    = PC + 32'd4;

    // ------------------------------------------------------------------
    // Decode fields and operand read
    // ------------------------------------------------------------------
    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [15:0] w_imm16;
    logic [25:0] w_target;
    logic [31:0] w_imm_sext;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;

    assign w_opcode   = w_instr[31:26];
    assign w_rs       = w_instr[25:21];
    assign w_rt       = w_instr[20:16];
    assign w_rd       = w_instr[15:11];
    assign w_shamt    = w_instr[10:6];
    assign w_funct    = w_instr[5:0];
    assign w_imm16    = w_instr[15:0];
    assign w_target   = w_instr[25:0];
    assign w_imm_sext = sign_ext16(w_imm16);

    // $0 reads as zero regardless of array contents (e.g. before first reset)
    assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : Reg_File[w_rs];
    assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : Reg_File[w_rt];

    // ------------------------------------------------------------------
    // ALU control
    // ------------------------------------------------------------------
    alu_op_e     w_alu_op;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_result;
    logic        w_alu_zero;

    always_comb begin
        w_alu_op = ALU_ADD;
        w_alu_b  = w_rt_val;
        case (w_opcode)
            c_OP_RTYPE: begin
                case (w_funct)
                    c_F_SUB: w_alu_op = ALU_SUB;
                    c_F_AND: w_alu_op = ALU_AND;
                    c_F_OR:  w_alu_op = ALU_OR;
                    c_F_SLT: w_alu_op = ALU_SLT;
                    c_F_SLL: w_alu_op = ALU_SLL;
                    c_F_SRL: w_alu_op = ALU_SRL;
                    default: w_alu_op = ALU_ADD;
                endcase
            end
            c_OP_ADDI, c_OP_LW, c_OP_SW: begin
                w_alu_op = ALU_ADD;
                w_alu_b  = w_imm_sext;
            end
            c_OP_SLTI: begin
                w_alu_op = ALU_SLT;
                w_alu_b  = w_imm_sext;
            end
            c_OP_BEQ, c_OP_BNE: begin
                w_alu_op = ALU_SUB;
            end
            default: begin
                w_alu_op = ALU_ADD;
            end
        endcase
    end

    mips_sim_alu u_alu (
        .i_a      (w_rs_val),
        .i_b      (w_alu_b),
        .i_shamt  (w_shamt),
        .i_alu_op (w_alu_op),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    // ------------------------------------------------------------------
    // Data memory access (word index = address[31:2])
    // ------------------------------------------------------------------
    logic [29:0] w_dm_widx;
    logic        w_dm_in_range;
    logic [31:0] w_dm_rdata;

    assign w_dm_widx     = w_alu_result[31:2];
    assign w_dm_in_range = ({2'b00, w_dm_widx} < 32'(DMEM_DEPTH));
    assign w_dm_rdata    = w_dm_in_range ? Data_Mem[w_dm_widx[c_DAW-1:0]] : 32'd0;

    // ------------------------------------------------------------------
    // Write-back and next-PC selection
    // ------------------------------------------------------------------
    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_rf_wdata;
    logic        w_dm_we;
    logic [31:0] w_pc_next;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;

    assign w_br_target = w_pc_plus4 + {w_imm_sext[29:0], 2'b00};
    assign w_j_target  = {w_pc_plus4[31:28], w_target, 2'b00};

    always_comb begin
        w_rf_we    = 1'b0;
        w_rf_waddr = w_rd;
        w_rf_wdata = w_alu_result;
        w_dm_we    = 1'b0;
        w_pc_next  = w_pc_plus4;
        case (w_opcode)
            c_OP_RTYPE: begin
                case (w_funct)
                    c_F_ADD, c_F_SUB, c_F_AND, c_F_OR,
                    c_F_SLT, c_F_SLL, c_F_SRL: w_rf_we   = 1'b1;
                    c_F_JR:                    w_pc_next = w_rs_val;
                    default:                   w_rf_we   = 1'b0;
                endcase
            end
            c_OP_ADDI, c_OP_SLTI: begin
                w_rf_we    = 1'b1;
                w_rf_waddr = w_rt;
            end
            c_OP_LW: begin
                w_rf_we    = 1'b1;
                w_rf_waddr = w_rt;
                w_rf_wdata = w_dm_rdata;
            end
            c_OP_SW: begin
                // Out-of-range stores are dropped rather than aliased
                w_dm_we = w_dm_in_range;
            end
            c_OP_BEQ: begin
                if (w_alu_zero) w_pc_next = w_br_target;
            end
            c_OP_BNE: begin
                if (!w_alu_zero) w_pc_next = w_br_target;
            end
            c_OP_J: begin
                w_pc_next = w_j_target;
            end
            c_OP_JAL: begin
                w_pc_next  = w_j_target;
                w_rf_we    = 1'b1;
                w_rf_waddr = 5'd31;
                w_rf_wdata = w_pc_plus4;
            end
            default: begin
                w_pc_next = w_pc_plus4;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            PC <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                Reg_File[i] <= '0;
            end
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                Data_Mem[i] <= '0;
            end
        end else begin
            PC <= w_pc_next;
            if (w_rf_we && (w_rf_waddr != 5'd0)) begin
                Reg_File[w_rf_waddr] <= w_rf_wdata;
            end
            if (w_dm_we) begin
                Data_Mem[w_dm_widx[c_DAW-1:0]] <= w_rt_val;
            end
        end
    end

`ifdef SIM_TRACE_EN
    // Trace reports the instruction being executed at this edge, using the
    // pre-edge decode values.
    logic [31:0] r_cycle;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cycle <= 32'd0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            $display("[cycle %0d] PC=%08h instr=%08h", r_cycle, PC, w_instr);
            if (w_rf_we && (w_rf_waddr != 5'd0)) begin
                $display("    Reg_File[%0d] <= %08h", w_rf_waddr, w_rf_wdata);
            end
            if (w_dm_we) begin
                $display("    Data_Mem[%0d] <= %08h", w_dm_widx, w_rt_val);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_isa_simulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_isa_simulator
//  Description : Self-checking bench for mips_isa_simulator. Directed
//                programs are loaded into Instr_Mem; expected architectural
//                state is queued on a scoreboard and a monitor process
//                compares it against the design state on falling edges.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_isa_simulator;

    localparam int OP_J    = 6'h02;
    localparam int OP_JAL  = 6'h03;
    localparam int OP_BEQ  = 6'h04;
    localparam int OP_BNE  = 6'h05;
    localparam int OP_ADDI = 6'h08;
    localparam int OP_SLTI = 6'h0A;
    localparam int OP_LW   = 6'h23;
    localparam int OP_SW   = 6'h2B;
    localparam int F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADD = 6'h20;
    localparam int F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

    localparam int KIND_REG = 0, KIND_DMEM = 1, KIND_PC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mips_isa_simulator #(
        .IMEM_DEPTH (256),
        .DMEM_DEPTH (256)
    ) dut (
        .clk_i (clk),
        .rst_i (rst)
    );

    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } chk_t;

    chk_t        sb[$];
    logic [31:0] prog[$];
    int          errors = 0;
    int          checks = 0;

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_r(input int funct, input int rs, input int rt,
                                          input int rd, input int sh);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], funct[5:0]};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] enc_j(input int op, input int target);
        return {op[5:0], target[25:0]};
    endfunction

    function automatic logic [31:0] self_loop();
        return enc_i(OP_BEQ, 0, 0, -1);
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic exp_reg(input string n, input int r, input int v);
        sb.push_back('{n, KIND_REG, r, v[31:0]});
    endtask

    task automatic exp_dmem(input string n, input int i, input int v);
        sb.push_back('{n, KIND_DMEM, i, v[31:0]});
    endtask

    task automatic exp_pc(input string n, input int v);
        sb.push_back('{n, KIND_PC, 0, v[31:0]});
    endtask

    function automatic logic [31:0] read_state(input int kind, input int idx);
        case (kind)
            KIND_REG:  return dut.Reg_File[idx];
            KIND_DMEM: return dut.Data_Mem[idx];
            default:   return dut.PC;
        endcase
    endfunction

    // Monitor: the design's observable output is its architectural state;
    // every queued expectation is compared on the next falling edge.
    initial begin
        chk_t        c;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                c   = sb.pop_front();
                act = read_state(c.kind, c.idx);
                checks++;
                if (act !== c.exp) begin
                    errors++;
                    $display("FAIL %s: actual=0x%08h expected=0x%08h", c.name, act, c.exp);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load_and_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 256; i++) dut.Instr_Mem[i] = 32'h0;
        foreach (prog[i]) dut.Instr_Mem[i] = prog[i];
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() > 0 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: actual=%0d pending expected=0 pending", sb.size());
            sb.delete();
        end
    endtask

    task automatic build_alu_prog();
        prog = {};
        prog.push_back(enc_i(OP_ADDI, 0, 1, 5));       // w0  $1 = 5
        prog.push_back(enc_i(OP_ADDI, 0, 2, -3));      // w1  $2 = -3
        prog.push_back(enc_r(F_ADD, 1, 2, 3, 0));      // w2  $3 = 2
        prog.push_back(enc_r(F_SUB, 1, 2, 4, 0));      // w3  $4 = 8
        prog.push_back(enc_r(F_SLT, 2, 1, 6, 0));      // w4  $6 = 1
        prog.push_back(enc_i(OP_SLTI, 1, 7, -1));      // w5  $7 = 0
        prog.push_back(enc_r(F_SLL, 0, 1, 8, 4));      // w6  $8 = 80
        prog.push_back(enc_i(OP_ADDI, 0, 9, -16));     // w7  $9 = -16
        prog.push_back(enc_r(F_SRL, 0, 9, 10, 28));    // w8  $10 = 15
        prog.push_back(enc_r(F_AND, 1, 2, 11, 0));     // w9  $11 = 5
        prog.push_back(enc_r(F_OR, 1, 2, 12, 0));      // w10 $12 = -3
        prog.push_back(self_loop());                   // w11
    endtask

    task automatic expect_alu_prog(input string t);
        exp_reg({t, "_add_r1"}, 1, 5);
        exp_reg({t, "_addi_neg_r2"}, 2, -3);
        exp_reg({t, "_add_r3"}, 3, 2);
        exp_reg({t, "_sub_r4"}, 4, 8);
        exp_reg({t, "_slt_r6"}, 6, 1);
        exp_reg({t, "_slti_r7"}, 7, 0);
        exp_reg({t, "_sll_r8"}, 8, 80);
        exp_reg({t, "_addi_r9"}, 9, -16);
        exp_reg({t, "_srl_r10"}, 10, 15);
        exp_reg({t, "_and_r11"}, 11, 5);
        exp_reg({t, "_or_r12"}, 12, -3);
        exp_pc({t, "_pc_loop"}, 44);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        // T1: ALU operations, plus reset state
        build_alu_prog();
        @(negedge clk);
        rst = 1'b1;
        foreach (prog[i]) dut.Instr_Mem[i] = prog[i];
        for (int i = prog.size(); i < 256; i++) dut.Instr_Mem[i] = 32'h0;
        run(2);
        exp_pc("reset_pc", 0);
        exp_reg("reset_r5", 5, 0);
        exp_dmem("reset_dm2", 2, 0);
        drain();
        @(negedge clk);
        rst = 1'b0;
        run(30);
        expect_alu_prog("t1");
        drain();

        // T2: memory access, $0 write discard, out-of-range and misaligned
        prog = {};
        prog.push_back(enc_i(OP_ADDI, 0, 16, 99));     // w0
        prog.push_back(enc_i(OP_ADDI, 0, 1, 7));       // w1
        prog.push_back(enc_i(OP_SW, 0, 1, 8));         // w2 Data_Mem[2] = 7
        prog.push_back(enc_i(OP_LW, 0, 5, 8));         // w3 $5 = 7
        prog.push_back(enc_i(OP_ADDI, 0, 0, 9));       // w4 discarded
        prog.push_back(enc_i(OP_SW, 0, 1, 1024));      // w5 index 256: ignored
        prog.push_back(enc_i(OP_LW, 0, 16, 1024));     // w6 $16 = 0
        prog.push_back(enc_i(OP_LW, 0, 17, 11));       // w7 $17 = Data_Mem[2]
        prog.push_back(self_loop());                   // w8
        load_and_reset();
        run(30);
        exp_reg("lw_r5", 5, 7);
        exp_dmem("sw_dm2", 2, 7);
        exp_reg("r0_zero", 0, 0);
        exp_reg("lw_oob_r16", 16, 0);
        exp_dmem("sw_oob_no_alias_dm0", 0, 0);
        exp_reg("lw_misaligned_r17", 17, 7);
        exp_pc("t2_pc_loop", 32);
        drain();

        // T3: branches and jumps
        prog = {};
        prog.push_back(enc_i(OP_ADDI, 0, 1, 1));       // w0
        prog.push_back(enc_i(OP_BEQ, 1, 1, 1));        // w1 taken
        prog.push_back(enc_i(OP_ADDI, 0, 2, 11));      // w2 skipped
        prog.push_back(enc_i(OP_BNE, 1, 0, 1));        // w3 taken
        prog.push_back(enc_i(OP_ADDI, 0, 3, 22));      // w4 skipped
        prog.push_back(enc_i(OP_BNE, 1, 1, 1));        // w5 not taken
        prog.push_back(enc_i(OP_ADDI, 0, 4, 33));      // w6
        prog.push_back(enc_j(OP_JAL, 10));             // w7 $31 = 32
        prog.push_back(enc_i(OP_ADDI, 0, 5, 44));      // w8 after return
        prog.push_back(enc_j(OP_J, 12));               // w9
        prog.push_back(enc_i(OP_ADDI, 0, 6, 55));      // w10
        prog.push_back(enc_r(F_JR, 31, 0, 0, 0));      // w11
        prog.push_back(self_loop());                   // w12
        load_and_reset();
        run(40);
        exp_reg("beq_skip_r2", 2, 0);
        exp_reg("bne_taken_r3", 3, 0);
        exp_reg("bne_not_taken_r4", 4, 33);
        exp_reg("jr_return_r5", 5, 44);
        exp_reg("jal_target_r6", 6, 55);
        exp_reg("jal_link_r31", 31, 32);
        exp_pc("t3_pc_loop", 48);
        drain();

        // T4: unknown opcode/funct and unloaded words are NOPs
        prog = {};
        prog.push_back(enc_i(OP_ADDI, 0, 1, 5));       // w0
        prog.push_back(32'hFC00_0000);                 // w1 opcode 0x3F
        prog.push_back(enc_r(6'h3F, 1, 1, 2, 0));      // w2 funct 0x3F
        load_and_reset();
        run(100);
        exp_pc("nop_pc_100", 400);
        exp_reg("nop_r1", 1, 5);
        exp_reg("unknown_funct_r2", 2, 0);
        exp_reg("nop_r31", 31, 0);
        drain();

        // T5: PC beyond instruction memory keeps advancing
        prog = {};
        prog.push_back(enc_i(OP_ADDI, 0, 1, 3));       // w0
        prog.push_back(enc_j(OP_J, 4096));             // w1 -> byte 16384
        load_and_reset();
        run(6);
        exp_pc("pc_oob_advance", 16400);
        exp_reg("pc_oob_r1", 1, 3);
        drain();

        // T6: reset mid-program, then re-execute
        build_alu_prog();
        load_and_reset();
        run(5);
        @(negedge clk);
        rst = 1'b1;
        run(1);
        exp_pc("midreset_pc", 0);
        for (int r = 0; r < 32; r++) exp_reg($sformatf("midreset_r%0d", r), r, 0);
        drain();
        @(negedge clk);
        rst = 1'b0;
        run(30);
        expect_alu_prog("t6");
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
